// File: rtl/event_encoder_if.sv
// Stream interface between the event encoder and its neighbours: the
// request/enable side, the valid/ready code output and the status outputs.
interface event_encoder_if #(
  parameter int N = 8,
  parameter int W = 3
) ();
  logic         e;
  logic [N-1:0] req;
  logic [W-1:0] code;
  logic         valid;
  logic         ready;
  logic [N-1:0] pending;
  logic         drop;

  // Encoder side: samples requests and ready, drives code/valid/status.
  modport master (
    input  e, req, ready,
    output code, valid, pending, drop
  );

  // Consumer/producer side: drives requests and ready, observes the rest.
  modport slave (
    output e, req, ready,
    input  code, valid, pending, drop
  );
endinterface

// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder. Multi-hot requests are captured into
// a pending register and emitted one index at a time on a valid/ready stream,
// selected round-robin starting from the slot after the last emitted index.
module event_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  event_encoder_if.master bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam logic [N-1:0] ONE = N'(1);

  out_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         drop_q, drop_d;

  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [W-1:0] idx;
  logic         load;
  logic [N-1:0] clr;
  logic [N-1:0] req_eff;

  // Round-robin search of the registered pending set, starting at ptr and
  // wrapping naturally because N is a power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip an assignment would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + W'(i);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Output-slot FSM next state plus pending/drop update.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ptr_d   = ptr_q;

    load    = ((state_q == EMPTY) || bus.ready) && sel_found;
    clr     = load ? (ONE << sel_idx) : '0;
    req_eff = bus.e ? bus.req : '0;

    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (bus.ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (load) begin
      code_d = sel_idx;
      ptr_d  = sel_idx + W'(1);
    end

    // A re-request of the bit being loaded survives as a new event; only a
    // request hitting a still-pending (not loaded) bit is a collision.
    pending_d = (pending_q & ~clr) | req_eff;
    drop_d    = |(req_eff & pending_q & ~clr);
  end

  // State registers with synchronous reset that discards everything in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      code_q    <= '0;
      ptr_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = (state_q == FULL);
  assign bus.pending = pending_q;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios against hand
// derived values, then randomized traffic against a behavioural model.
module tb_event_encoder;
  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  event_encoder_if #(.N(N), .W(W)) bus ();

  event_encoder #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: pending set, output slot and rotation start.
  logic [N-1:0] m_pend;
  logic         m_valid;
  logic [W-1:0] m_code;
  int           m_ptr;
  logic         m_drop;

  task automatic model_step(input logic r, input logic ev, input logic [N-1:0] rq,
                            input logic rdy);
    logic [N-1:0] clr;
    logic [N-1:0] nreq;
    bit           ld;
    int           sel;
    if (r) begin
      m_pend = '0; m_valid = 1'b0; m_code = '0; m_ptr = 0; m_drop = 1'b0;
    end else begin
      clr = '0;
      sel = -1;
      ld  = (!m_valid || rdy) && (m_pend != 0);
      if (ld) begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && m_pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        clr = N'(1) << sel;
      end
      nreq   = ev ? rq : '0;
      m_drop = (nreq & m_pend & ~clr) != 0;
      m_pend = (m_pend & ~clr) | nreq;
      if (ld) begin
        m_valid = 1'b1;
        m_code  = W'(sel);
        m_ptr   = (sel + 1) % N;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: model consumes the same inputs the DUT samples, then settle.
  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.e, bus.req, bus.ready);
    #1;
  endtask

  task automatic drive(input logic r, input logic ev, input logic [N-1:0] rq,
                       input logic rdy);
    rst = r; bus.e = ev; bus.req = rq; bus.ready = rdy;
  endtask

  function automatic logic [12:0] obs();
    return {bus.valid, bus.code, bus.pending, bus.drop};
  endfunction

  task automatic test_reset();
    drive(1, 1, 8'hFF, 0);
    tick();
    n_cmp++;
    if (obs() !== 13'h0) begin
      n_err++; $display("FAIL reset: got %h expected %h", obs(), 13'h0);
    end
  endtask

  task automatic test_single();
    drive(0, 1, 8'h04, 1);
    tick();
    n_cmp++;
    if (obs() !== {1'b0, 3'd0, 8'h04, 1'b0}) begin
      n_err++; $display("FAIL single_capture: got %h expected %h", obs(), {1'b0, 3'd0, 8'h04, 1'b0});
    end
    drive(0, 1, 8'h00, 1);
    tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd2, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL single_emit: got %h expected %h", obs(), {1'b1, 3'd2, 8'h00, 1'b0});
    end
    tick();
    n_cmp++;
    if (obs() !== {1'b0, 3'd2, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL single_drain: got %h expected %h", obs(), {1'b0, 3'd2, 8'h00, 1'b0});
    end
  endtask

  task automatic test_disabled();
    drive(0, 0, 8'hFF, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({bus.valid, bus.pending, bus.drop} !== 10'h0) begin
        n_err++; $display("FAIL disabled_cycle%0d: got v=%b p=%h d=%b expected all 0",
                          i, bus.valid, bus.pending, bus.drop);
      end
    end
  endtask

  task automatic test_multi();
    logic [W-1:0] exp_codes[3] = '{3'd1, 3'd4, 3'd7};
    drive(1, 0, 8'h00, 1); tick();
    drive(0, 1, 8'h92, 1); tick();
    drive(0, 1, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.valid, bus.code} !== {1'b1, exp_codes[i]}) begin
        n_err++; $display("FAIL multi_code%0d: got v=%b c=%0d expected v=1 c=%0d",
                          i, bus.valid, bus.code, exp_codes[i]);
      end
    end
    tick();
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL multi_empty: got v=%b expected 0", bus.valid);
    end
    // Rotation start must be back at 0: a full request emits index 0 first.
    drive(0, 1, 8'hFF, 1); tick();
    drive(0, 1, 8'h00, 1); tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL multi_ptr_wrap: got v=%b c=%0d expected v=1 c=0", bus.valid, bus.code);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_wrap();
    drive(1, 0, 8'h00, 1); tick();
    drive(0, 1, 8'h10, 1); tick();
    drive(0, 1, 8'h42, 1); tick();
    n_cmp++;
    if ({bus.valid, bus.code, bus.pending} !== {1'b1, 3'd4, 8'h42}) begin
      n_err++; $display("FAIL wrap_code4: got %h expected %h",
                        {bus.valid, bus.code, bus.pending}, {1'b1, 3'd4, 8'h42});
    end
    drive(0, 1, 8'h00, 1); tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd6}) begin
      n_err++; $display("FAIL wrap_code6: got v=%b c=%0d expected v=1 c=6", bus.valid, bus.code);
    end
    tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL wrap_code1: got v=%b c=%0d expected v=1 c=1", bus.valid, bus.code);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, 0, 8'h00, 0); tick();
    drive(0, 1, 8'h28, 0); tick();
    drive(0, 1, 8'h00, 0); tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd3, 8'h20, 1'b0}) begin
      n_err++; $display("FAIL bp_hold: got %h expected %h", obs(), {1'b1, 3'd3, 8'h20, 1'b0});
    end
    drive(0, 1, 8'h20, 0); tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd3, 8'h20, 1'b1}) begin
      n_err++; $display("FAIL bp_drop: got %h expected %h", obs(), {1'b1, 3'd3, 8'h20, 1'b1});
    end
    drive(0, 1, 8'h00, 0); tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd3, 8'h20, 1'b0}) begin
      n_err++; $display("FAIL bp_drop_once: got %h expected %h", obs(), {1'b1, 3'd3, 8'h20, 1'b0});
    end
    drive(0, 1, 8'h08, 0); tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd3, 8'h28, 1'b0}) begin
      n_err++; $display("FAIL bp_held_code_req: got %h expected %h", obs(), {1'b1, 3'd3, 8'h28, 1'b0});
    end
    drive(0, 1, 8'h00, 1); tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd5}) begin
      n_err++; $display("FAIL bp_release5: got v=%b c=%0d expected v=1 c=5", bus.valid, bus.code);
    end
    tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd3}) begin
      n_err++; $display("FAIL bp_release3: got v=%b c=%0d expected v=1 c=3", bus.valid, bus.code);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 8'h00, 0); tick();
    drive(0, 1, 8'hF0, 0); tick();
    drive(0, 1, 8'h10, 0); tick();
    n_cmp++;
    if (obs() !== {1'b1, 3'd4, 8'hF0, 1'b0}) begin
      n_err++; $display("FAIL rstmid_setup: got %h expected %h", obs(), {1'b1, 3'd4, 8'hF0, 1'b0});
    end
    drive(1, 1, 8'hF0, 0); tick();
    n_cmp++;
    if (obs() !== 13'h0) begin
      n_err++; $display("FAIL rstmid_clear: got %h expected %h", obs(), 13'h0);
    end
    drive(0, 1, 8'h01, 1); tick();
    drive(0, 1, 8'h00, 1); tick();
    n_cmp++;
    if ({bus.valid, bus.code} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL rstmid_first: got v=%b c=%0d expected v=1 c=0", bus.valid, bus.code);
    end
    tick();
  endtask

  task automatic test_random();
    drive(1, 0, 8'h00, 0); tick();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            N'($urandom_range(0, 255) & $urandom_range(0, 255)),
            ($urandom_range(0, 2) != 0));
      tick();
      n_cmp++;
      if (obs() !== {m_valid, m_code, m_pend, m_drop}) begin
        n_err++; $display("FAIL random_cycle%0d: got %h expected %h",
                          i, obs(), {m_valid, m_code, m_pend, m_drop});
      end
    end
  endtask

  initial begin
    bus.e = 1'b0; bus.req = '0; bus.ready = 1'b0;
    m_pend = '0; m_valid = 1'b0; m_code = '0; m_ptr = 0; m_drop = 1'b0;
    test_reset();
    test_single();
    test_disabled();
    test_multi();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
